// File: rtl/lsu_controller.sv
`default_nettype none
// ============================================================================
// Module   : lsu_controller
// Purpose  : Load/store sequencer between the core and a handshaked data bus.
//            Converts a one-cycle mem_read/mem_write request into a REQ/RSP
//            bus transaction and stalls the core until it completes. It also
//            generates byte enables and replicates store data across lanes.
//            Load data is sign- or zero-extended. Misaligned or illegal
//            accesses raise access_fault and never reach the bus.
// Ports    : clk, rst (async, active-high)
//            mem_read, mem_write, func3, addr, write_data  - core request
//            stall, read_data, access_fault, bus_error     - core status
//            bus_req_valid/ready, bus_addr, bus_we, bus_wdata, bus_byte_en
//                                                          - bus request
//            bus_rsp_valid, bus_rdata                      - bus response
// Options  : define LSU_TIMEOUT_EN to enable the REQ/WAIT_RSP watchdog.
//            TIMEOUT_CYCLES sets its limit in cycles.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_controller #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [2:0]              func3,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    output logic                    stall,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    access_fault,
    output logic                    bus_error,
    output logic                    bus_req_valid,
    input  logic                    bus_req_ready,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic                    bus_we,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    output logic [DATA_WIDTH/8-1:0] bus_byte_en,
    input  logic                    bus_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   bus_rdata
);

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_REQ      = 2'd1;
    localparam logic [1:0] c_S_WAIT_RSP = 2'd2;
    localparam logic [1:0] c_S_DONE     = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              r_offset;     // addr[1:0] captured for load extraction
    logic [1:0]              r_size;       // func3[1:0]: 00 byte, 01 half, 10 word
    logic                    r_unsigned;   // func3[2]: zero-extend loads

    logic                    w_single;
    logic                    w_legal;
    logic                    w_aligned;
    logic                    w_accept;
    logic                    w_tmo_hit;
    logic [DATA_WIDTH/8-1:0] w_byte_en;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load_ext;

    // ------------------------------------------------------------------
    // Request decode (meaningful only in IDLE)
    // ------------------------------------------------------------------
    assign w_single = mem_read ^ mem_write;

    always_comb begin
        w_legal = 1'b0;
        if (mem_read) begin
            case (func3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_legal = 1'b1;
                default:                                w_legal = 1'b0;
            endcase
        end else if (mem_write) begin
            case (func3)
                3'b000, 3'b001, 3'b010: w_legal = 1'b1;
                default:                w_legal = 1'b0;
            endcase
        end
    end

    always_comb begin
        case (func3[1:0])
            2'b01:   w_aligned = ~addr[0];
            2'b10:   w_aligned = (addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_accept     = (r_state == c_S_IDLE) & w_single & w_legal & w_aligned;
    // Both request lines high is a decoder error even if func3 looks legal.
    assign access_fault = (r_state == c_S_IDLE) &
                          ((mem_read & mem_write) | (w_single & ~(w_legal & w_aligned)));
    assign stall        = w_accept | (r_state == c_S_REQ) | (r_state == c_S_WAIT_RSP);

    always_comb begin
        case (func3[1:0])
            2'b00: begin
                w_byte_en = 4'b0001 << addr[1:0];
                w_wdata   = {4{write_data[7:0]}};
            end
            2'b01: begin
                w_byte_en = 4'b0011 << addr[1:0];
                w_wdata   = {2{write_data[15:0]}};
            end
            default: begin
                w_byte_en = 4'b1111;
                w_wdata   = write_data;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data extraction from the captured offset/size/sign
    // ------------------------------------------------------------------
    always_comb begin
        case (r_offset)
            2'd0:    w_byte = bus_rdata[7:0];
            2'd1:    w_byte = bus_rdata[15:8];
            2'd2:    w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = r_offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (r_size)
            2'b00:   w_load_ext = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load_ext = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_ext = bus_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef LSU_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_TMO_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == c_S_REQ) || (r_state == c_S_WAIT_RSP)) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    // Fires on the cycle whose increment would reach the limit, so the FSM
    // spends exactly TIMEOUT_CYCLES cycles in REQ/WAIT_RSP before DONE.
    assign w_tmo_hit = ((r_state == c_S_REQ) || (r_state == c_S_WAIT_RSP)) &&
                       ((r_tmo_cnt + 1'b1) == c_TMO_LIMIT);
`else
    assign w_tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_S_IDLE;
            r_offset      <= 2'd0;
            r_size        <= 2'd0;
            r_unsigned    <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_addr      <= '0;
            bus_we        <= 1'b0;
            bus_wdata     <= '0;
            bus_byte_en   <= '0;
            read_data     <= '0;
            bus_error     <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_accept) begin
                        r_state       <= c_S_REQ;
                        r_offset      <= addr[1:0];
                        r_size        <= func3[1:0];
                        r_unsigned    <= func3[2];
                        bus_req_valid <= 1'b1;
                        bus_addr      <= {addr[ADDR_WIDTH-1:2], 2'b00};
                        bus_we        <= mem_write;
                        bus_wdata     <= w_wdata;
                        bus_byte_en   <= w_byte_en;
                        bus_error     <= 1'b0;
                    end
                end
                c_S_REQ: begin
                    // Response is not looked at here; it must follow acceptance.
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        r_state       <= c_S_WAIT_RSP;
                    end else if (w_tmo_hit) begin
                        bus_req_valid <= 1'b0;
                        bus_error     <= 1'b1;
                        read_data     <= '0;
                        r_state       <= c_S_DONE;
                    end
                end
                c_S_WAIT_RSP: begin
                    if (bus_rsp_valid) begin
                        if (!bus_we) begin
                            read_data <= w_load_ext;
                        end
                        r_state <= c_S_DONE;
                    end else if (w_tmo_hit) begin
                        bus_error <= 1'b1;
                        read_data <= '0;
                        r_state   <= c_S_DONE;
                    end
                end
                default: begin
                    // DONE: requests are not sampled, so the retiring
                    // instruction is never issued twice.
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_controller
// Purpose  : Self-checking bench for lsu_controller. It applies a vector
//            table, hand-written corner sequences and randomized
//            transactions. Results are compared with a byte-level reference
//            model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        stall;
    logic [31:0] read_data;
    logic        access_fault;
    logic        bus_error;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byte_en;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    lsu_controller #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .func3         (func3),
        .addr          (addr),
        .write_data    (write_data),
        .stall         (stall),
        .read_data     (read_data),
        .access_fault  (access_fault),
        .bus_error     (bus_error),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_addr      (bus_addr),
        .bus_we        (bus_we),
        .bus_wdata     (bus_wdata),
        .bus_byte_en   (bus_byte_en),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    logic [31:0] model_rd = 32'd0;   // value read_data should hold

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rdat;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] rdx;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: access size in bytes, lane offset and plain arithmetic.
    function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rdat,
                                  output logic acc, output logic fault,
                                  output logic [3:0] be, output logic [31:0] wdat,
                                  output logic [31:0] rdx);
        int          nbytes;
        int          off;
        logic        legal;
        logic        single;
        logic [31:0] mask;
        nbytes = 1 << f3[1:0];
        off    = int'(a % 4);
        legal  = rd ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
                    : (f3 <= 3'd2);
        single = rd ^ wr;
        acc    = single && legal && ((off % nbytes) == 0);
        fault  = (rd && wr) || (single && !acc);
        be     = 4'd0;
        wdat   = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nbytes) be[i] = 1'b1;
            wdat[8*i +: 8] = wd[8*(i % nbytes) +: 8];
        end
        mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        rdx  = (rdat >> (8 * off)) & mask;
        if (!f3[2] && nbytes < 4 && rdx[8*nbytes-1]) rdx = rdx | ~mask;
    endfunction

    // Entry and exit: #1 after a rising edge with the DUT in IDLE.
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdat, input int rdy_dly, input int rsp_dly,
                           input logic exp_acc, input logic exp_fault,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_read, input string tag,
                           output int stall_seen);
        stall_seen = 0;
        mem_read   = rd;
        mem_write  = wr;
        func3      = f3;
        addr       = a;
        write_data = wd;
        @(negedge clk);
        check({tag, ".fault"}, 32'(access_fault), 32'(exp_fault));
        check({tag, ".stall_idle"}, 32'(stall), 32'(exp_acc));
        check({tag, ".valid_idle"}, 32'(bus_req_valid), 32'd0);
        if (stall) stall_seen++;
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (!exp_acc) begin
            @(negedge clk);
            check({tag, ".no_req"}, 32'(bus_req_valid), 32'd0);
            @(posedge clk); #1;
            return;
        end
        for (int k = 0; k <= rdy_dly; k++) begin
            if (k == rdy_dly) bus_req_ready = 1'b1;
            @(negedge clk);
            check({tag, ".valid"}, 32'(bus_req_valid), 32'd1);
            check({tag, ".addr"}, bus_addr, {a[31:2], 2'b00});
            check({tag, ".we"}, 32'(bus_we), 32'(wr));
            check({tag, ".be"}, 32'(bus_byte_en), 32'(exp_be));
            if (wr) check({tag, ".wdata"}, bus_wdata, exp_wdata);
            if (stall) stall_seen++;
            @(posedge clk); #1;
        end
        bus_req_ready = 1'b0;
        for (int k = 1; k <= rsp_dly; k++) begin
            if (k == rsp_dly) begin
                bus_rsp_valid = 1'b1;
                bus_rdata     = rdat;
            end
            @(negedge clk);
            check({tag, ".stall_wait"}, 32'(stall), 32'd1);
            check({tag, ".valid_wait"}, 32'(bus_req_valid), 32'd0);
            if (stall) stall_seen++;
            @(posedge clk); #1;
        end
        bus_rsp_valid = 1'b0;
        bus_rdata     = $urandom;
        @(negedge clk);
        check({tag, ".stall_done"}, 32'(stall), 32'd0);
        check({tag, ".read_data"}, read_data, exp_read);
        check({tag, ".bus_error"}, 32'(bus_error), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int          seen;
        int          cyc;
        logic        acc;
        logic        flt;
        logic [3:0]  be;
        logic [31:0] wdat;
        logic [31:0] rdx;

        rst           = 1'b1;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        func3         = 3'd0;
        addr          = 32'd0;
        write_data    = 32'd0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = 32'd0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.valid", 32'(bus_req_valid), 32'd0);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.read_data", read_data, 32'd0);
        check("rst.bus_addr", bus_addr, 32'd0);
        check("rst.wdata", bus_wdata, 32'd0);
        check("rst.be", 32'(bus_byte_en), 32'd0);
        check("rst.we_err", {30'd0, bus_we, bus_error}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- vector table ----------------
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 1'b0, 4'h8, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 1'b0, 4'h8, 32'h0,        32'h00000080};
        vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h80FFFFFF, 1'b0, 4'hC, 32'h0,        32'h000080FF};
        vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80FFFFFF, 1'b0, 4'hC, 32'h0,        32'hFFFF80FF};
        vecs[5]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h55555555, 1'b0, 4'h2, 32'hA5A5A5A5, 32'hFFFF80FF};
        vecs[6]  = '{1'b0, 1'b1, 3'b010, 32'h204, 32'h12345678, 32'h55555555, 1'b0, 4'hF, 32'h12345678, 32'hFFFF80FF};
        vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'hFFFF80FF};
        vecs[8]  = '{1'b1, 1'b1, 3'b010, 32'h100, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'hFFFF80FF};
        vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'hFFFF80FF};
        vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'hFFFF80FF};
        vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'hFFFF80FF};

        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rdat,
                    0, (i == 0) ? 2 : 1, !vecs[i].fault, vecs[i].fault, vecs[i].be,
                    vecs[i].wdat, vecs[i].rdx, $sformatf("vec%0d", i), seen);
            if (i == 0) check("lw.stall_cycles", 32'(seen), 32'd4);
            if (vecs[i].fault) check($sformatf("vec%0d.fault_nostall", i), 32'(seen), 32'd0);
        end
        model_rd = 32'hFFFF80FF;

        // ---------------- SH with ready held low 3 cycles ----------------
        run_txn(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 3, 1, 1'b1, 1'b0,
                4'hC, 32'hABCDABCD, model_rd, "sh_hold", seen);

        // ---------------- reset in REQ ----------------
        mem_read = 1'b1; func3 = 3'b010; addr = 32'h300;
        @(posedge clk); #1;
        mem_read = 1'b0;
        @(negedge clk);
        check("rstreq.valid_before", 32'(bus_req_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstreq.valid_after", 32'(bus_req_valid), 32'd0);
        check("rstreq.stall_after", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- reset in WAIT_RSP ----------------
        mem_read = 1'b1; func3 = 3'b010; addr = 32'h304;
        @(posedge clk); #1;
        mem_read      = 1'b0;
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        @(negedge clk);
        check("rstwait.stall_before", 32'(stall), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstwait.stall_after", 32'(stall), 32'd0);
        check("rstwait.valid_after", 32'(bus_req_valid), 32'd0);
        check("rstwait.read_data", read_data, 32'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        model_rd = 32'd0;
        run_txn(1'b1, 1'b0, 3'b010, 32'h308, 32'h0, 32'hCAFEF00D, 0, 1, 1'b1, 1'b0,
                4'hF, 32'h0, 32'hCAFEF00D, "post_rst_lw", seen);
        model_rd = 32'hCAFEF00D;

        // ---------------- bus never answers ----------------
        mem_read = 1'b1; func3 = 3'b010; addr = 32'h400;
        @(posedge clk); #1;
        mem_read = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cyc = 0;
        @(negedge clk);
        while (stall === 1'b1 && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        check("tmo.cycles", 32'(cyc), 32'd8);
        check("tmo.bus_error", 32'(bus_error), 32'd1);
        check("tmo.read_data", read_data, 32'd0);
        check("tmo.valid", 32'(bus_req_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("tmo.error_holds", 32'(bus_error), 32'd1);
        @(posedge clk); #1;
        model_rd = 32'd0;
`else
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (stall === 1'b1 && bus_req_valid === 1'b1) cyc++;
        end
        check("hang.stall_cycles", 32'(cyc), 32'd20);
        check("hang.bus_error", 32'(bus_error), 32'd0);
        @(posedge clk); #1;
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'h11223344;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        check("hang.done_stall", 32'(stall), 32'd0);
        check("hang.read_data", read_data, 32'h11223344);
        @(posedge clk); #1;
        model_rd = 32'h11223344;
`endif

        // ---------------- randomized transactions ----------------
        for (int n = 0; n < 300; n++) begin
            logic        rd;
            logic        wr;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] wd;
            logic [31:0] rdat;
            int          kind;
            kind = $urandom_range(0, 9);
            rd   = (kind == 0) || (kind >= 2 && kind <= 5);
            wr   = (kind == 0) || (kind >= 6);
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom & 32'h0000_0FFF;
            wd   = $urandom;
            rdat = $urandom;
            model(rd, wr, f3, a, wd, rdat, acc, flt, be, wdat, rdx);
            if (acc && rd) model_rd = rdx;
            run_txn(rd, wr, f3, a, wd, rdat, $urandom_range(0, 2), $urandom_range(1, 3),
                    acc, flt, be, wdat, model_rd, $sformatf("rnd%0d", n), seen);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
